// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    // Arbiter sequencing: wait for a request, run the memory access, present the response.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Which port owns the transaction currently in flight.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // Memory word is split into this many byte lanes, lane 0 = most significant byte.
    localparam int NUM_LANES = 4;

endpackage

// File: rtl/mem_arb_priority.sv
// Grant selection between the fetch and data ports.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin on contention;
// otherwise the data port (the older instruction) always wins.
module mem_arb_priority
    import mem_arb_pkg::*;
(
    input  logic   fetch_req,
    input  logic   data_req,
    input  owner_t last_served,
    output logic   grant,
    output owner_t owner
);

    assign grant = fetch_req | data_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On contention, serve whichever port was not served last.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        owner = OWN_FETCH;
        if (fetch_req && data_req)
            owner = (last_served == OWN_DATA) ? OWN_FETCH : OWN_DATA;
        else if (data_req)
            owner = OWN_DATA;
    end
`else
    // Fixed priority: data access beats instruction fetch.
    always_comb begin
        owner = data_req ? OWN_DATA : OWN_FETCH;
    end

    // History is irrelevant under fixed priority.
    logic unused_last_served;
    assign unused_last_served = last_served;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// One transaction at a time: grant, hold the address for MEM_LATENCY cycles,
// capture the read word, then pulse the owner's valid for one cycle.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_priority).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_valid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [XLEN-1:0] dm_addr,
    input  logic [XLEN-1:0] dm_wdata,
    output logic            dm_valid,
    output logic [XLEN-1:0] dm_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [7:0]      mem_data_in  [0:NUM_LANES-1],
    input  logic [7:0]      mem_data_out [0:NUM_LANES-1],
    output logic            mem_write_en,
    output logic            stall
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    owner_t          last_q, last_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] if_rdata_q, dm_rdata_q;
    logic            capture;

    logic            fetch_req_m, data_req_m, grant;
    owner_t          grant_owner;
    logic [31:0]     rd_word;

    // The port just being answered cannot win again in its response cycle;
    // its request line still shows the transaction that is completing.
    assign fetch_req_m = if_req & ~(state_q == ST_RESP && owner_q == OWN_FETCH);
    assign data_req_m  = dm_req & ~(state_q == ST_RESP && owner_q == OWN_DATA);

    mem_arb_priority u_priority (
        .fetch_req   (fetch_req_m),
        .data_req    (data_req_m),
        .last_served (last_q),
        .grant       (grant),
        .owner       (grant_owner)
    );

    // Reassemble the read lanes: lane 0 carries the most significant byte.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_LANES; i++)
            rd_word[8*(NUM_LANES-1-i) +: 8] = mem_data_out[i];
    end

    // Next-state logic: arbitrate from IDLE/RESP, count down the access, then respond.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (grant) begin
                    state_d = ST_ACCESS;
                    owner_d = grant_owner;
                    last_d  = grant_owner;
                    cnt_d   = CNT_INIT;
                    addr_d  = (grant_owner == OWN_DATA) ? dm_addr : if_addr;
                    we_d    = (grant_owner == OWN_DATA) && dm_we;
                    wdata_d = dm_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and transaction registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_b) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_FETCH;
            last_q     <= OWN_DATA;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            if (capture) begin
                if (owner_q == OWN_FETCH)
                    if_rdata_q <= XLEN'(rd_word);
                else if (!we_q)
                    dm_rdata_q <= XLEN'(rd_word);
            end
        end
    end

    // Write lanes follow the same big-endian byte order as the read lanes.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_wlane
        assign mem_data_in[i] = wdata_q[8*(NUM_LANES-1-i) +: 8];
    end

    assign if_valid     = (state_q == ST_RESP) && (owner_q == OWN_FETCH);
    assign dm_valid     = (state_q == ST_RESP) && (owner_q == OWN_DATA);
    assign if_rdata     = if_rdata_q;
    assign dm_rdata     = dm_rdata_q;
    assign mem_addr     = (state_q == ST_ACCESS) ? (addr_q & ~XLEN'(3)) : '0;
    assign mem_write_en = (state_q == ST_ACCESS) && (owner_q == OWN_DATA) && we_q &&
                          (cnt_q == CNT_INIT);
    assign stall        = (if_req & ~if_valid) | (dm_req & ~dm_valid);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter MEM_LATENCY, default 2: cycles from memory address presentation to valid mem_data_out; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset; synchronous, active-high.
REQ-005 if_req  input  1  instruction-fetch request; held high until if_valid.
REQ-006 if_addr  input  XLEN  fetch address (PC); stable while if_req is high.
REQ-007 if_valid  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 if_rdata  output  XLEN  fetched instruction word.
REQ-009 dm_req  input  1  data-access request; held high until dm_valid.
REQ-010 dm_we  input  1  1 = store, 0 = load; stable while dm_req is high.
REQ-011 dm_addr  input  XLEN  data address (ALU result); stable while dm_req is high.
REQ-012 dm_wdata  input  XLEN  store data (rt value).
REQ-013 dm_valid  output  1  one-cycle pulse: load data ready or store committed.
REQ-014 dm_rdata  output  XLEN  load data.
REQ-015 mem_addr  output  XLEN  shared memory address.
REQ-016 mem_data_in  output  4x8 unpacked [0:3]  write byte lanes.
REQ-017 mem_data_out  input  4x8 unpacked [0:3]  read byte lanes.
REQ-018 mem_write_en  output  1  memory write strobe.
REQ-019 stall  output  1  freezes PC and pipeline: (if_req & ~if_valid) | (dm_req & ~dm_valid).

Function
REQ-020 FSM states: IDLE, ACCESS, RESP; one owner (FETCH or DATA) is latched per transaction.
REQ-021 In IDLE or RESP, when any unmasked request is present, the arbiter SHALL grant, latch owner/addr/we/wdata, and enter ACCESS with the counter at MEM_LATENCY-1.
REQ-022 In RESP, the current owner's request SHALL be masked for arbitration in that cycle.
REQ-023 Without a pending request, IDLE SHALL hold and RESP SHALL return to IDLE.
REQ-024 In ACCESS, the counter SHALL decrement each cycle; at zero, mem_data_out SHALL be registered into the owner's rdata and the FSM SHALL enter RESP.
REQ-025 The owner's valid SHALL be high in RESP only; read latency is request-in-IDLE to valid = MEM_LATENCY+1 cycles.
REQ-026 mem_write_en SHALL be high only in the first ACCESS cycle of a DATA store; FETCH never writes.
REQ-027 mem_addr SHALL equal the latched address with bits [1:0] forced to 0 throughout ACCESS, and 0 otherwise.
REQ-028 Byte order: lane [0] = word bits [31:24], lane [3] = bits [7:0], for both read and write.
REQ-029 if_rdata/dm_rdata SHALL hold their last value until overwritten by a transaction of the same owner; a store SHALL NOT modify dm_rdata.
REQ-030 Simultaneous if_req and dm_req SHALL grant DATA (the older instruction) by default.
REQ-031 With MEM_LATENCY=1, ACCESS SHALL last exactly one cycle.

Reset
REQ-032 When rst_b is high at a clock edge: state=IDLE, counter=0, owner=FETCH, if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0; mem_write_en and mem_addr are 0 from the next cycle.
REQ-033 Reset during ACCESS SHALL abort the transaction: no valid pulse and no further write strobe.

Configuration
REQ-034 Macro MEM_ARB_ROUND_ROBIN_EN: when defined, simultaneous requests SHALL grant the owner not served last (last-served flag, reset to DATA, so FETCH wins first); when undefined, fixed DATA priority per REQ-030.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum, the owner enum, and the lane-count constant (4).
REQ-036 Grant selection SHALL live in sub-module mem_arb_priority (inputs: masked requests, last-served; output: owner).

Verification
REQ-037 MEM_LATENCY=2, load if_addr=0x100 with mem_data_out={0x12,0x34,0x56,0x78} -> if_valid on cycle 3, if_rdata=0x12345678, stall high cycles 0-2.
REQ-038 Store dm_addr=0x203, dm_wdata=0xDEADBEEF -> mem_addr=0x200, one mem_write_en pulse, mem_data_in={DE,AD,BE,EF}, dm_valid on cycle 3.
REQ-039 if_req and dm_req both rise on the same cycle -> dm_valid cycle 3, if_valid cycle 6 (default); with MEM_ARB_ROUND_ROBIN_EN -> if_valid cycle 3, dm_valid cycle 6.
REQ-040 Continuous if_req with a new address after each valid -> back-to-back grants from RESP, one valid every MEM_LATENCY+1 cycles.
REQ-041 rst_b asserted in ACCESS of a store -> no valid, mem_write_en 0, state IDLE; a following load completes normally.
